// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_t;

  localparam logic [6:0]  SEG_BLANK      = 7'h7F;
  localparam int unsigned DIGITS_DEFAULT = 8;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit 6 = segment a, bit 0 = segment g.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      4'hF: seg = 7'h38;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered frame data and
// blanking gaps between digits to suppress ghosting.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = DIGITS_DEFAULT,
  parameter int unsigned SHOW_CYC  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_data,
  input  logic [DIGITS-1:0]   load_mask,
  output logic [DIGITS-1:0]   an_out,
  output logic [6:0]          seg_out,
  output logic                frame_done
);

  localparam int unsigned IDX_W   = $clog2(DIGITS);
  localparam int unsigned MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;

  logic [4*DIGITS-1:0] act_data, pend_data;
  logic [DIGITS-1:0]   act_mask, pend_mask;
  logic                act_valid, pend_valid;

  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic                last_idx, blank_end, show_end, xfer, load_fire;

  always_comb begin
    cur_nib = act_data[{idx, 2'b00} +: 4];
  end

  hex7seg u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  assign last_idx   = (idx == IDX_W'(DIGITS - 1));
  assign blank_end  = (cnt == CNT_W'(BLANK_CYC - 1));
  assign show_end   = (cnt == CNT_W'(SHOW_CYC - 1));
  assign frame_done = (state == StShow) && last_idx && show_end;
  assign load_ready = ~pend_valid;
  // Transfer only needs pend_valid, so it can never coincide with an accepted load.
  assign xfer       = pend_valid && ((state == StIdle) || frame_done);
  assign load_fire  = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      idx        <= '0;
      cnt        <= '0;
      act_data   <= '0;
      act_mask   <= '0;
      act_valid  <= 1'b0;
      pend_data  <= '0;
      pend_mask  <= '0;
      pend_valid <= 1'b0;
      an_out     <= '1;
      seg_out    <= SEG_BLANK;
    end else begin
      if (xfer) begin
        act_data   <= pend_data;
        act_mask   <= pend_mask;
        act_valid  <= 1'b1;
        pend_valid <= 1'b0;
      end else if (load_fire) begin
        pend_data  <= load_data;
        pend_mask  <= load_mask;
        pend_valid <= 1'b1;
      end

      // Outputs reflect the state held during this cycle, so they trail it by one edge.
      an_out  <= '1;
      seg_out <= SEG_BLANK;
      if (state == StShow) begin
        an_out[idx] <= ~act_mask[idx];
        if (act_mask[idx]) begin
          seg_out <= dec_seg;
        end
      end

      if (!en) begin
        state <= StIdle;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (act_valid || xfer) begin
              state <= StBlank;
              idx   <= '0;
              cnt   <= '0;
            end
          end
          StBlank: begin
            if (blank_end) begin
              state <= StShow;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          StShow: begin
            if (show_end) begin
              state <= StBlank;
              cnt   <= '0;
              idx   <= last_idx ? '0 : idx + IDX_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= StIdle;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-cycle expectations queued per frame, popped while scanning.
module tb_seg_scan_ctrl;

  localparam int unsigned D     = 4;
  localparam int unsigned SC    = 4;
  localparam int unsigned BC    = 1;
  localparam int unsigned FRAME = D * (SC + BC);

  localparam logic [6:0] SEG_REF [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        rst, en, load_valid, load_ready, frame_done;
  logic [15:0] load_data;
  logic [3:0]  load_mask, an_out;
  logic [6:0]  seg_out;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS    (D),
    .SHOW_CYC  (SC),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_mask  (load_mask),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the FRAME cycles following the edge that starts a frame.
  task automatic push_frame(input logic [15:0] data, input logic [3:0] mask);
    for (int k = 1; k <= int'(FRAME); k++) begin
      exp_t e;
      int   d  = (k - 1) / int'(SC + BC);
      int   ph = (k - 1) % int'(SC + BC);
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.fd  = (k == int'(FRAME) - 1);
      if (ph != 0 && mask[d]) begin
        e.an  = ~(4'b0001 << d);
        e.seg = SEG_REF[data[4*d +: 4]];
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input bit skip, input int ld_k, input logic [15:0] ld_d,
                           input logic [3:0] ld_m, input bit dup);
    exp_t e;
    if (skip) @(posedge clk);
    for (int k = 1; k <= int'(FRAME); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_empty", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("an k=%0d", k), 16'(an_out), 16'(e.an));
        chk($sformatf("seg k=%0d", k), 16'(seg_out), 16'(e.seg));
        chk($sformatf("fd k=%0d", k), 16'(frame_done), 16'(e.fd));
      end
      if (ld_k != 0) begin
        if (k == ld_k) begin
          load_valid = 1'b1;
          load_data  = ld_d;
          load_mask  = ld_m;
        end else if (k == ld_k + 1) begin
          chk("ready_after_load", 16'(load_ready), 16'd0);
          if (dup) begin
            load_data = 16'h0000;
            load_mask = 4'hF;
          end else begin
            load_valid = 1'b0;
          end
        end else if (k == ld_k + 2 && dup) begin
          chk("ready_dup", 16'(load_ready), 16'd0);
          load_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_mask  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 16'(an_out), 16'hF);
    chk("rst_seg", 16'(seg_out), 16'h7F);
    chk("rst_fd", 16'(frame_done), 16'd0);
    chk("rst_ready", 16'(load_ready), 16'd1);

    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_empty_an", 16'(an_out), 16'hF);
    chk("idle_empty_seg", 16'(seg_out), 16'h7F);

    load_valid = 1'b1;
    load_data  = 16'h1234;
    load_mask  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    chk("ready_pending", 16'(load_ready), 16'd0);

    push_frame(16'h1234, 4'hF);
    run_frame(1'b1, 0, 16'h0, 4'h0, 1'b0);
    // Mid-frame load plus a rejected second offer; old data must persist to frame end.
    push_frame(16'h1234, 4'hF);
    run_frame(1'b0, 7, 16'hFFFF, 4'hF, 1'b1);
    chk("ready_after_xfer", 16'(load_ready), 16'd1);
    push_frame(16'hFFFF, 4'hF);
    run_frame(1'b0, 3, 16'h7650, 4'hF, 1'b0);
    push_frame(16'h7650, 4'hF);
    run_frame(1'b0, 3, 16'hCBA9, 4'hF, 1'b0);
    push_frame(16'hCBA9, 4'hF);
    run_frame(1'b0, 3, 16'h8888, 4'b0101, 1'b0);
    push_frame(16'h8888, 4'b0101);
    run_frame(1'b0, 0, 16'h0, 4'h0, 1'b0);

    // Drop enable while digit 2 is on the display.
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("d2_an", 16'(an_out), 16'b1011);
    chk("d2_seg", 16'(seg_out), 16'h00);
    en = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("en_off_an", 16'(an_out), 16'hF);
    chk("en_off_seg", 16'(seg_out), 16'h7F);
    chk("en_off_fd", 16'(frame_done), 16'd0);
    repeat (3) @(negedge clk);
    chk("en_off_hold_an", 16'(an_out), 16'hF);
    en = 1'b1;
    push_frame(16'h8888, 4'b0101);
    run_frame(1'b1, 0, 16'h0, 4'h0, 1'b0);

    // Reset during SHOW of digit 0, with a load offered in the reset cycle.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h5555;
    load_mask  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    chk("mid_rst_an", 16'(an_out), 16'hF);
    chk("mid_rst_seg", 16'(seg_out), 16'h7F);
    chk("mid_rst_fd", 16'(frame_done), 16'd0);
    chk("mid_rst_ready", 16'(load_ready), 16'd1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst_an %0d", i), 16'(an_out), 16'hF);
      chk($sformatf("post_rst_seg %0d", i), 16'(seg_out), 16'h7F);
    end
    chk("post_rst_ready", 16'(load_ready), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter: DIGITS, 8, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter: SHOW_CYC, 50000, clock cycles each digit is driven.
REQ-003 SHALL have parameter: BLANK_CYC, 16, cycles with all digits off before each digit (anti-ghosting).
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: en  input  1  scan enable; 0 blanks the display.
REQ-007 SHALL have port: load_valid  input  1  new frame offered.
REQ-008 SHALL have port: load_ready  output  1  pending buffer empty.
REQ-009 SHALL have port: load_data  input  4*DIGITS  hex nibbles, digit i = bits [4i+3:4i].
REQ-010 SHALL have port: load_mask  input  DIGITS  per-digit enable, 1 = shown.
REQ-011 SHALL have port: an_out  output  DIGITS  digit select, active-low, at most one bit low.
REQ-012 SHALL have port: seg_out  output  7  segments a..g (bit 6 = a), active-low.
REQ-013 SHALL have port: frame_done  output  1  one-cycle pulse at end of last digit.

Function
REQ-014 SHALL implement states IDLE, BLANK, SHOW, with a digit index idx (0..DIGITS-1) and a dwell counter cnt.
REQ-015 SHALL hold an active buffer (data, mask, valid) and a pending buffer (data, mask, valid); load_ready = ~pending.valid.
REQ-016 SHALL accept a load when load_valid && load_ready: pending captures data/mask, pending.valid <= 1 on that edge.
REQ-017 SHALL transfer pending to active, and clear pending.valid, on the edge where state is IDLE or frame_done is 1; it SHALL NOT transfer mid-frame.
REQ-018 SHALL give a transfer priority over a simultaneous load; that load is not accepted in that cycle because load_ready is 0.
REQ-019 IDLE: SHALL move to BLANK with idx = 0 and cnt = 0 when en = 1 and active.valid = 1, including an active.valid set on this same edge.
REQ-020 BLANK: SHALL drive an_out all-1 and seg_out 7'h7F, and SHALL move to SHOW after BLANK_CYC cycles (cnt = BLANK_CYC-1), resetting cnt.
REQ-021 SHOW: SHALL drive an_out[idx] = ~mask[idx] with all other bits 1, and seg_out = decode(nibble idx) if mask[idx] = 1, else 7'h7F.
REQ-022 SHOW: after SHOW_CYC cycles SHALL move to BLANK with idx+1; at idx = DIGITS-1, idx SHALL wrap to 0 and frame_done SHALL be 1 in that cycle.
REQ-023 en = 0 in any state SHALL force IDLE on the next edge with idx = 0 and cnt = 0; the buffers SHALL be retained.
REQ-024 IDLE SHALL drive an_out all-1, seg_out 7'h7F and frame_done 0.
REQ-025 SHALL decode the hex nibble to segments for 0..F (active-low, e.g. 0 -> 7'h01, 1 -> 7'h4F, 8 -> 7'h00, F -> 7'h38).
REQ-026 an_out and seg_out SHALL be registered and change one cycle after the state/idx change they reflect.
REQ-027 cnt SHALL be wide enough for max(SHOW_CYC, BLANK_CYC) and SHALL never wrap within a dwell.

Reset
REQ-028 On rst = 1 at a clock edge, the block SHALL enter IDLE with idx = 0 and cnt = 0, and both valid flags SHALL be 0.
REQ-029 On that reset edge, outputs SHALL go to an_out all-1, seg_out 7'h7F, frame_done 0 and load_ready 1.
REQ-030 Reset mid-frame SHALL discard both buffers; a load offered during the reset cycle SHALL be ignored.

Structure
REQ-031 Package seg_pkg SHALL hold the state enum, the blank code 7'h7F and the default DIGITS.
REQ-032 The decoder SHALL be the single sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated once and shared across digits via idx.

Verification (DIGITS=4, SHOW_CYC=4, BLANK_CYC=1)
REQ-033 Reset, en=1, load 16'h1234 mask 4'hF -> digits 0..3 each shown 4 cycles: seg 7'h4C(4), 7'h06(3), 7'h12(2), 7'h4F(1); frame_done pulses every 20 cycles.
REQ-034 Mask 4'b0101, data 16'h8888 -> an_out low only for digits 0 and 2 (seg 7'h00); digits 1 and 3 blank (an all-1, seg 7'h7F).
REQ-035 Mid-frame load of 16'hFFFF -> load_ready drops; old value is shown until frame_done; the next frame shows 7'h38 on all digits; load_ready then returns to 1.
REQ-036 A second load while pending is full -> load_ready = 0, the load is not taken, the first pending value wins.
REQ-037 en dropped during digit 2 -> next cycle IDLE, all blank; en reasserted -> scanning restarts at digit 0 with the retained data.
REQ-038 rst pulse during SHOW -> next cycle all blank, load_ready = 1; with en=1 and no new load the display stays blank.
